mem_arbiter: RTL

Arbitrates a single-ported, fixed-latency main memory between the instruction-fetch refill path and the data-cache refill/writeback path of the 5-stage pipeline. Each requester holds a request until it gets a one-cycle acknowledge. The data side has priority, and a starvation counter guarantees forward progress for fetch. The block sequences each memory transaction through issue, latency wait and response.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported, fixed-latency main memory shared by the fetch and data-cache refill paths.
// The data side has priority, and a starvation counter bounds how long fetch can be locked out.
//
// Handshake: each requester holds its req, and its address and data, until it sees a one-cycle ack.
// A request is sampled only in IDLE. Address and data are latched at grant.
// The arbiter never acks both sides in one cycle and keeps at most one memory transaction outstanding.
module mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int LINE_W       = 128,
   parameter int MEM_LATENCY  = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ack,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              arb_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);
   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        starve_q, starve_d;
   logic              gnt_dc_q, gnt_dc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
   logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
   logic              starved;

   // Fetch is forced only when it is actually waiting and has lost STARVE_LIMIT times in a row.
   assign starved = ic_req && (starve_q == LIMIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      gnt_dc_d   = gnt_dc_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ic_rdata_d = ic_rdata_q;
      dc_rdata_d = dc_rdata_q;
      case (state_q)
         IDLE: begin
            if (dc_req && !starved) begin
               state_d  = ISSUE;
               gnt_dc_d = 1'b1;
               we_d     = dc_we;
               addr_d   = dc_addr;
               wdata_d  = dc_wdata;
               if (ic_req && (starve_q < LIMIT)) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (ic_req) begin
               state_d  = ISSUE;
               gnt_dc_d = 1'b0;
               we_d     = 1'b0;
               addr_d   = ic_addr;
               wdata_d  = '0;
               starve_d = '0;
            end
         end
         ISSUE: begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = RESP;
               // A writeback leaves the data-side line register untouched.
               if (!gnt_dc_q) begin
                  ic_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  dc_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         gnt_dc_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         gnt_dc_q   <= gnt_dc_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ic_rdata_q <= ic_rdata_d;
         dc_rdata_q <= dc_rdata_d;
      end
   end

   assign mem_req   = (state_q == ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign ic_ack    = (state_q == RESP) && !gnt_dc_q;
   assign dc_ack    = (state_q == RESP) && gnt_dc_q;
   assign ic_rdata  = ic_rdata_q;
   assign dc_rdata  = dc_rdata_q;
   assign arb_busy  = (state_q != IDLE);

endmodule
